// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller with BOOT/RUN/HALT sequencing and retired-instruction counter
// Optional feature macro: PC_ALIGN_TRAP_EN (misaligned JR target traps to TRAP_VECTOR, adds epc port)
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   pc_cur / pc_next      current PC in, combinational next PC out
//   stall                 hold PC, no retire
//   branch_eq/branch_ne   conditional branches qualified by alu_zero
//   jump/jump_reg         J/JAL and JR/JALR, with jump_index / reg_target
//   imm_ext               sign-extended branch offset (word units)
//   halt_req/resume       enter and leave HALT
//   fetch_valid, state    execute-enable and FSM state (00 BOOT, 01 RUN, 10 HALT)
//   retired_count         wrapping retire counter
//   trap (epc)            misalignment trap pulse and faulting PC
module pc_sequencer #(
   parameter int          COUNT_W     = 32,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        pc_cur,
   output logic [31:0]        pc_next,
   input  logic               stall,
   input  logic               branch_eq,
   input  logic               branch_ne,
   input  logic               alu_zero,
   input  logic               jump,
   input  logic               jump_reg,
   input  logic [31:0]        imm_ext,
   input  logic [25:0]        jump_index,
   input  logic [31:0]        reg_target,
   input  logic               halt_req,
   input  logic               resume,
   output logic               fetch_valid,
   output logic [1:0]         state,
   output logic [COUNT_W-1:0] retired_count,
   output logic               trap
`ifdef PC_ALIGN_TRAP_EN
   ,
   output logic [31:0]        epc
`endif
);
   typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_plus4, br_target, j_target, jr_target, sel_target;
   logic        taken, retire, misaligned;
   assign state      = state_q;
   assign pc_plus4   = pc_cur + 32'd4;
   assign br_target  = pc_plus4 + (imm_ext << 2);
   assign j_target   = {pc_plus4[31:28], jump_index, 2'b00};
   assign jr_target  = {reg_target[31:2], 2'b00};
   assign taken      = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);
   assign sel_target = jump_reg ? jr_target : jump ? j_target : taken ? br_target : pc_plus4;
`ifdef PC_ALIGN_TRAP_EN
   assign misaligned = jump_reg & (reg_target[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif
   always_comb begin
      pc_next     = pc_cur;
      fetch_valid = 1'b0;
      retire      = 1'b0;
      trap        = 1'b0;
      state_d     = BOOT;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            fetch_valid = 1'b1;
            state_d     = RUN;
            if (!stall) begin
               // a trapping JR does not retire and suppresses a same-cycle halt
               if (misaligned) begin
                  pc_next = TRAP_VECTOR;
                  trap    = 1'b1;
               end else begin
                  retire  = 1'b1;
                  pc_next = halt_req ? pc_plus4 : sel_target;
                  state_d = halt_req ? HALT : RUN;
               end
            end
         end
         HALT: state_d = resume ? RUN : HALT;
         default: state_d = BOOT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= BOOT;
         retired_count <= '0;
      end else begin
         state_q       <= state_d;
         retired_count <= retired_count + COUNT_W'(retire);
      end
   end
`ifdef PC_ALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset) epc <= '0;
      else if (trap) epc <= pc_cur;
   end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] pc_cur = '0, imm_ext = '0, reg_target = '0, pc_next;
   logic        stall = 0, branch_eq = 0, branch_ne = 0, alu_zero = 0, jump = 0, jump_reg = 0;
   logic        halt_req = 0, resume = 0, fetch_valid, trap;
   logic [25:0] jump_index = '0;
   logic [1:0]  state;
   logic [31:0] retired_count;
`ifdef PC_ALIGN_TRAP_EN
   logic [31:0] epc;
`endif
   int          checks = 0, failures = 0;
   int          st = 0;
   logic [31:0] cnt = '0, m_epc = '0;
   pc_sequencer dut (
      .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next), .stall(stall),
      .branch_eq(branch_eq), .branch_ne(branch_ne), .alu_zero(alu_zero), .jump(jump),
      .jump_reg(jump_reg), .imm_ext(imm_ext), .jump_index(jump_index), .reg_target(reg_target),
      .halt_req(halt_req), .resume(resume), .fetch_valid(fetch_valid), .state(state),
      .retired_count(retired_count), .trap(trap)
`ifdef PC_ALIGN_TRAP_EN
      , .epc(epc)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic bit exp_trap();
`ifdef PC_ALIGN_TRAP_EN
      return st == 1 && !stall && jump_reg && reg_target[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction
   function automatic logic [31:0] exp_pc();
      logic [31:0] p4;
      p4 = pc_cur + 32'd4;
      if (st != 1 || stall) return pc_cur;
      if (exp_trap()) return 32'h0000_0080;
      if (halt_req) return p4;
      if (jump_reg) return reg_target & ~32'd3;
      if (jump) return {p4[31:28], jump_index, 2'b00};
      if ((branch_eq && alu_zero) || (branch_ne && !alu_zero)) return p4 + imm_ext * 4;
      return p4;
   endfunction
   task automatic cyc();
      @(negedge clk);
      check("state", 32'(state), 32'(st));
      check("fetch_valid", 32'(fetch_valid), 32'(st == 1));
      check("pc_next", pc_next, exp_pc());
      check("retired_count", retired_count, cnt);
      check("trap", 32'(trap), 32'(exp_trap()));
`ifdef PC_ALIGN_TRAP_EN
      check("epc", epc, m_epc);
`endif
      if (reset) begin
         st = 0; cnt = '0; m_epc = '0;
      end else if (st == 0) st = 1;
      else if (st == 1) begin
         if (!stall) begin
            if (exp_trap()) m_epc = pc_cur;
            else begin
               cnt++;
               if (halt_req) st = 2;
            end
         end
      end else if (st == 2 && resume) st = 1;
      @(posedge clk);
      #1;
   endtask
   task automatic clr();
      {stall, branch_eq, branch_ne, alu_zero, jump, jump_reg, halt_req, resume} = '0;
      imm_ext = '0; reg_target = '0; jump_index = '0;
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      cyc();
      reset = 0;
      #1 check("boot_pc", pc_next, 32'h0);
      cyc();
      #1 check("run_pc", pc_next, 32'h4);
      cyc();
      pc_cur = 32'h4; cyc();
      pc_cur = 32'h100; branch_eq = 1; alu_zero = 1; imm_ext = 32'hFFFF_FFFE;
      #1 check("beq_taken", pc_next, 32'hFC);
      cyc();
      alu_zero = 0;
      #1 check("beq_not", pc_next, 32'h104);
      cyc();
      branch_eq = 0; branch_ne = 1; imm_ext = 32'd3;
      #1 check("bne_taken", pc_next, 32'h110);
      cyc();
      clr(); pc_cur = 32'h4000_0010; jump = 1; jump_index = 26'h40; branch_eq = 1; alu_zero = 1;
      #1 check("jump", pc_next, 32'h4000_0100);
      cyc();
      jump_reg = 1; reg_target = 32'h2000;
      #1 check("jr", pc_next, 32'h2000);
      cyc();
      clr(); pc_cur = 32'h20; stall = 1; jump = 1; halt_req = 1;
      repeat (3) begin
         #1 check("stall_pc", pc_next, 32'h20);
         cyc();
      end
      clr(); pc_cur = 32'h40; halt_req = 1;
      #1 check("halt_pc", pc_next, 32'h44);
      cyc();
      halt_req = 0; pc_cur = 32'h44; jump = 1;
      #1 check("halted_fv", 32'(fetch_valid), 32'h0);
      cyc();
      resume = 1; cyc();
      resume = 0; jump = 0;
      #1 check("resumed_pc", pc_next, 32'h48);
      cyc();
      pc_cur = 32'h48; halt_req = 1; cyc();
      halt_req = 0; reset = 1; cyc();
      reset = 0;
      #1 check("reset_halt_state", 32'(state), 32'h0);
      cyc();
      pc_cur = 32'hFFFF_FFFC;
      #1 check("wrap_pc", pc_next, 32'h0);
      cyc();
      pc_cur = 32'h30; jump_reg = 1; reg_target = 32'h1002;
`ifdef PC_ALIGN_TRAP_EN
      #1 check("trap_pc", pc_next, 32'h80);
      cyc();
      #1 check("epc_val", epc, 32'h30);
`else
      #1 check("jr_align", pc_next, 32'h1000);
`endif
      cyc();
      clr();
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 39) == 0);
         pc_cur     = $urandom() & ~32'd3;
         if ($urandom_range(0, 9) == 0) pc_cur = 32'hFFFF_FFFC;
         stall      = ($urandom_range(0, 4) == 0);
         branch_eq  = 1'($urandom());
         branch_ne  = 1'($urandom());
         alu_zero   = 1'($urandom());
         jump       = ($urandom_range(0, 3) == 0);
         jump_reg   = ($urandom_range(0, 3) == 0);
         halt_req   = ($urandom_range(0, 7) == 0);
         resume     = ($urandom_range(0, 2) == 0);
         imm_ext    = 32'(signed'(16'($urandom())));
         jump_index = 26'($urandom());
         reg_target = $urandom();
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the single-cycle MIPS core. It drives the PC register's PC_in from the current PC and the decode/ALU control signals.
- Selects among sequential, branch, jump and jump-register targets. Applies stalls by re-presenting the current PC.
- Runs a small BOOT/RUN/HALT state machine and keeps a retired-instruction counter.

Parameters:
- COUNT_W, 32, width of retired_count (wraps modulo 2^COUNT_W)
- TRAP_VECTOR, 32'h0000_0080, target address on misalignment trap (used only with PC_ALIGN_TRAP_EN)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; resets state and counter on the rising edge where it is high
- pc_cur  input  32  current PC (PC register output)
- pc_next  output  32  next PC (to PC register input); combinational
- stall  input  1  hold PC this cycle (hazard/memory wait)
- branch_eq  input  1  BEQ decoded
- branch_ne  input  1  BNE decoded
- alu_zero  input  1  ALU zero flag
- jump  input  1  J/JAL decoded
- jump_reg  input  1  JR/JALR decoded
- imm_ext  input  32  sign-extended 16-bit immediate
- jump_index  input  26  instruction[25:0]
- reg_target  input  32  rs value for JR
- halt_req  input  1  halt instruction decoded
- resume  input  1  leave HALT
- fetch_valid  output  1  instruction at pc_cur is to be executed this cycle
- state  output  2  00 BOOT, 01 RUN, 10 HALT
- retired_count  output  COUNT_W  instructions retired since reset
- trap  output  1  misalignment trap pulse (tied 0 without PC_ALIGN_TRAP_EN)

Behaviour:
- Arithmetic, all 32-bit with wrap-around:
  - pc_plus4 = pc_cur + 4, so 32'hFFFF_FFFC wraps to 0
  - br_target = pc_plus4 + (imm_ext << 2)
  - j_target = {pc_plus4[31:28], jump_index, 2'b00}
- taken = (branch_eq & alu_zero) | (branch_ne & ~alu_zero).
- Selection priority in RUN: jump_reg > jump > taken > pc_plus4.
- Outputs after reset: state = BOOT, retired_count = 0, fetch_valid = 0, trap = 0, pc_next = pc_cur.
- BOOT:
  - Lasts exactly one cycle; the PC register is 0 and instruction memory is settling.
  - pc_next = pc_cur, fetch_valid = 0.
  - Goes to RUN unconditionally.
- RUN:
  - fetch_valid = 1.
  - If stall = 1: pc_next = pc_cur, no retire, all other controls are ignored, and state stays RUN. Stall beats halt_req.
  - Otherwise pc_next = the selected target and retired_count increments by 1.
  - If halt_req = 1 (and stall = 0): the halt instruction retires, pc_next = pc_plus4, and the next state is HALT. halt_req overrides branch and jump.
- HALT:
  - pc_next = pc_cur, fetch_valid = 0, no retire.
  - resume = 1 moves to RUN on the next edge; pc is unchanged in that cycle.
  - stall, halt_req and control inputs are ignored.
- Simultaneous events: multiple control signals resolve by the priority above. resume outside HALT is ignored.
- Reset mid-operation, in any state: next state BOOT and counter 0. The PC register independently reloads 0.
- retired_count wraps at 2^COUNT_W and does not saturate.
- Latency: pc_next is combinational (0 cycles). state and counter change one edge after the triggering inputs.
- Unused state encoding 11 goes to BOOT.

Optional Feature:
PC_ALIGN_TRAP_EN
- Defined:
  - In RUN with stall = 0 and jump_reg = 1: if reg_target[1:0] != 0, pc_next = TRAP_VECTOR and trap = 1 for that cycle.
  - The offending instruction does not retire. Output epc[31:0] registers pc_cur on that edge (reset 0).
  - halt_req in the same cycle is ignored.
- Undefined:
  - trap tied 0, no epc port.
  - The JR target is used with bits [1:0] forced to 00.

Test Plan:
- Reset at pc_cur = 0, then release → state BOOT for 1 cycle with pc_next = 0 and fetch_valid = 0; next cycle state RUN, pc_next = 4, retired_count increments each cycle thereafter.
- pc_cur = 0x100, branch_eq = 1, alu_zero = 1, imm_ext = 0xFFFF_FFFE → pc_next = 0xFC; with alu_zero = 0 → pc_next = 0x104; with branch_ne = 1, alu_zero = 0, imm_ext = 3 → pc_next = 0x110.
- pc_cur = 0x4000_0010, jump = 1, jump_index = 0x000_0040, branch taken also asserted → pc_next = 0x4000_0100; jump_reg = 1 with reg_target = 0x2000 as well → pc_next = 0x2000.
- stall = 1 for 3 cycles at pc_cur = 0x20 with jump = 1 and halt_req = 1 → pc_next = 0x20 each cycle, retired_count unchanged, state stays RUN.
- halt_req at pc_cur = 0x40 → pc_next = 0x44, count +1, then HALT holds with fetch_valid = 0; resume → RUN one edge later, pc_next = 0x48; reset asserted while in HALT → BOOT, count = 0.
- pc_cur = 0xFFFF_FFFC sequential → pc_next = 0. With PC_ALIGN_TRAP_EN: jump_reg with reg_target = 0x1002 at pc_cur = 0x30 → pc_next = 0x80, trap = 1, epc = 0x30, count unchanged. Without the macro → pc_next = 0x1000.
